// File: rtl/regfile_sb.sv
// Register file with two bypassed read ports, one write port and a per-register
// pending-write scoreboard. Define REGFILE_DEBUG_EN to enable the dbg_addr/dbg_data read port.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              claim_ok,
  input  logic              flush,
  output logic              err_underflow,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              err_q, err_d;

  logic wr_live;     // write to a real (non-zero) register
  logic wr_retire;   // write that retires an outstanding claim
  logic claim_acc;   // accepted claim on a real register
  logic drop1, drop2;

  assign wr_live   = wr_en && (wr_addr != '0);
  assign wr_retire = wr_live && (pend_q[wr_addr] != '0);

  assign claim_ok  = (claim_addr == '0) ||
                     (pend_q[claim_addr] != PEND_MAX) ||
                     (wr_retire && (wr_addr == claim_addr));
  assign claim_acc = claim_en && claim_ok && (claim_addr != '0);

  // Reader sees busy drop in the same cycle the last claim retires, unless a new claim replaces it.
  assign drop1 = wr_retire && (wr_addr == rd_addr1) && (pend_q[rd_addr1] == PEND_ONE) &&
                 !(claim_acc && (claim_addr == rd_addr1));
  assign drop2 = wr_retire && (wr_addr == rd_addr2) && (pend_q[rd_addr2] == PEND_ONE) &&
                 !(claim_acc && (claim_addr == rd_addr2));

  assign rd_data1 = (rd_addr1 == '0) ? '0 :
                    (wr_en && (wr_addr == rd_addr1)) ? wr_data : regs_q[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 :
                    (wr_en && (wr_addr == rd_addr2)) ? wr_data : regs_q[rd_addr2];
  assign rd_busy1 = (rd_addr1 != '0) && (pend_q[rd_addr1] != '0) && !drop1;
  assign rd_busy2 = (rd_addr2 != '0) && (pend_q[rd_addr2] != '0) && !drop2;

  assign err_d         = err_q || (wr_live && (pend_q[wr_addr] == '0) &&
                                   !(claim_acc && (claim_addr == wr_addr)));
  assign err_underflow = err_q;

  // claim_acc and wr_retire both exclude address 0, so pend[0] never leaves zero.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    logic inc, dec;
    assign inc = claim_acc && (claim_addr == ADDR_W'(gi));
    assign dec = wr_retire && (wr_addr == ADDR_W'(gi));
    assign pend_d[gi] = flush        ? '0 :
                        (inc && !dec) ? pend_q[gi] + PEND_ONE :
                        (dec && !inc) ? pend_q[gi] - PEND_ONE : pend_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) pend_q[i] <= pend_d[i];
      if (wr_live) regs_q[wr_addr] <= wr_data;
      err_q <= err_d;
    end
  end

`ifdef REGFILE_DEBUG_EN
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`else
  logic unused_dbg;
  assign unused_dbg = ^dbg_addr;
  assign dbg_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed checks of regfile_sb against an array-based reference model.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PEND_W = 2;
  localparam int NREG   = 32;
  localparam int PMAX   = 3;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, claim_addr, dbg_addr;
  logic [DATA_W-1:0] rd_data1, rd_data2, wr_data, dbg_data;
  logic rd_busy1, rd_busy2, wr_en, claim_en, claim_ok, flush, err_underflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  logic [DATA_W-1:0] m_reg [NREG];
  int                m_pend [NREG];
  bit                m_err;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
    .flush(flush), .err_underflow(err_underflow),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 0;
    end
    m_err = 0;
  endtask

  function automatic bit m_claim_ok();
    int c = int'(claim_addr);
    return (c == 0) || (m_pend[c] < PMAX) ||
           (wr_en && int'(wr_addr) == c && m_pend[c] != 0);
  endfunction

  function automatic bit m_claim_to(int a);
    return claim_en && a != 0 && int'(claim_addr) == a && m_claim_ok();
  endfunction

  function automatic logic [DATA_W-1:0] m_data(int a);
    if (a == 0) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic bit m_busy(int a);
    if (a == 0 || m_pend[a] == 0) return 0;
    if (wr_en && int'(wr_addr) == a && m_pend[a] == 1 && !m_claim_to(a)) return 0;
    return 1;
  endfunction

  function automatic logic [DATA_W-1:0] m_dbg();
`ifdef REGFILE_DEBUG_EN
    return (dbg_addr == '0) ? '0 : m_reg[int'(dbg_addr)];
`else
    return '0;
`endif
  endfunction

  task automatic model_clock();
    int  w   = int'(wr_addr);
    int  c   = int'(claim_addr);
    bit  inc = m_claim_to(c);
    bit  dec = wr_en && w != 0 && m_pend[w] != 0;
    bit  und = wr_en && w != 0 && m_pend[w] == 0 && !m_claim_to(w);
    if (und) m_err = 1;
    if (wr_en && w != 0) m_reg[w] = wr_data;
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_pend[i] = 0;
    end else begin
      if (inc) m_pend[c] = m_pend[c] + 1;
      if (dec) m_pend[w] = m_pend[w] - 1;
    end
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, "_rd_data1"}, rd_data1, m_data(int'(rd_addr1)));
    check_eq({ctx, "_rd_busy1"}, rd_busy1, m_busy(int'(rd_addr1)));
    check_eq({ctx, "_rd_data2"}, rd_data2, m_data(int'(rd_addr2)));
    check_eq({ctx, "_rd_busy2"}, rd_busy2, m_busy(int'(rd_addr2)));
    check_eq({ctx, "_claim_ok"}, claim_ok, m_claim_ok());
    check_eq({ctx, "_err"}, err_underflow, m_err);
    check_eq({ctx, "_dbg"}, dbg_data, m_dbg());
  endtask

  // One transaction: check combinational outputs mid-cycle, then advance model with the edge.
  task automatic cycle(input string ctx);
    @(negedge clk);
    check_outputs(ctx);
    $display("txn %0d %s: wr=%0b a=%0d d=%h claim=%0b a=%0d ok=%0b flush=%0b err=%0b",
             n_txn, ctx, wr_en, wr_addr, wr_data, claim_en, claim_addr, claim_ok, flush, err_underflow);
    n_txn++;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; claim_en = 0; flush = 0;
    wr_addr = '0; wr_data = '0; claim_addr = '0;
  endtask

  initial begin
    rst = 1; idle();
    rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state visible on every address of both ports
    for (int a = 0; a < NREG; a++) begin
      rd_addr1 = ADDR_W'(a); rd_addr2 = ADDR_W'(NREG - 1 - a); claim_addr = ADDR_W'(a);
      #1;
      check_eq("rst_data1", rd_data1, 0);
      check_eq("rst_busy1", rd_busy1, 0);
      check_eq("rst_data2", rd_data2, 0);
      check_eq("rst_busy2", rd_busy2, 0);
      check_eq("rst_claim_ok", claim_ok, 1);
    end
    check_eq("rst_err", err_underflow, 0);
    idle();

    // Claim r5, then retire it with a bypassed write
    claim_en = 1; claim_addr = 5; rd_addr1 = 5; rd_addr2 = 0;
    cycle("claim5");
    idle(); #1;
    check_eq("r5_busy", rd_busy1, 1);
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; #1;
    check_eq("r5_bypass_data", rd_data1, 32'hDEADBEEF);
    check_eq("r5_bypass_busy", rd_busy1, 0);
    cycle("wr5");
    idle(); #1;
    check_eq("r5_data", rd_data1, 32'hDEADBEEF);
    check_eq("r5_busy_after", rd_busy1, 0);

    // Saturating claims on r7
    rd_addr1 = 7;
    for (int k = 0; k < 3; k++) begin
      claim_en = 1; claim_addr = 7; #1;
      check_eq("r7_claim_ok", claim_ok, 1);
      cycle("claim7");
    end
    claim_en = 1; claim_addr = 7; #1;
    check_eq("r7_claim_full", claim_ok, 0);
    cycle("claim7_rej");
    wr_en = 1; wr_addr = 7; wr_data = 32'h7777; #1;
    check_eq("r7_claim_retire", claim_ok, 1);
    cycle("claim7_wr7");
    idle(); claim_en = 1; claim_addr = 7; #1;
    check_eq("r7_still_full", claim_ok, 0);
    check_eq("r7_busy", rd_busy1, 1);
    idle();

    // Register 0 writes and claims are no-ops
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678; claim_en = 1; claim_addr = 0; rd_addr1 = 0;
    #1;
    check_eq("r0_data", rd_data1, 0);
    check_eq("r0_busy", rd_busy1, 0);
    check_eq("r0_claim_ok", claim_ok, 1);
    cycle("r0");
    idle(); #1;
    check_eq("r0_data_after", rd_data1, 0);
    check_eq("r0_no_underflow", err_underflow, 0);

    // Underflow on r9, then flush clears claims on r3
    wr_en = 1; wr_addr = 9; wr_data = 32'hA5; rd_addr1 = 9; rd_addr2 = 3;
    cycle("wr9");
    idle(); #1;
    check_eq("r9_data", rd_data1, 32'hA5);
    check_eq("r9_err", err_underflow, 1);
    for (int k = 0; k < 2; k++) begin
      claim_en = 1; claim_addr = 3;
      cycle("claim3");
    end
    idle(); #1;
    check_eq("r3_busy", rd_busy2, 1);
    flush = 1;
    cycle("flush");
    idle(); #1;
    check_eq("r3_flushed", rd_busy2, 0);
    check_eq("r9_kept", rd_data1, 32'hA5);
    check_eq("err_held", err_underflow, 1);

    // Asynchronous reset between edges
    wr_en = 1; wr_addr = 4; wr_data = 32'h55; rd_addr1 = 4; dbg_addr = 4;
    cycle("wr4");
    idle(); #1;
    check_eq("r4_data", rd_data1, 32'h55);
    check_eq("r4_dbg", dbg_data, m_dbg());
    #1 rst = 1; #1;
    model_reset();
    check_eq("arst_r4", rd_data1, 0);
    check_eq("arst_dbg", dbg_data, 0);
    check_eq("arst_err", err_underflow, 0);
    @(posedge clk); #1 rst = 0;

    // Randomized traffic, focused on a few addresses to force collisions
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        idle(); rst = 1; #1; model_reset();
        check_eq("rand_arst_err", err_underflow, 0);
        @(posedge clk); #1 rst = 0;
      end
      wr_en      = ($urandom_range(0, 9) < 4);
      wr_addr    = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 5));
      wr_data    = $urandom;
      claim_en   = ($urandom_range(0, 9) < 6);
      claim_addr = ADDR_W'($urandom_range(0, 5));
      flush      = ($urandom_range(0, 49) == 0);
      rd_addr1   = ADDR_W'($urandom_range(0, 5));
      rd_addr2   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom);
      dbg_addr   = ADDR_W'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the dynamic-issue CPU core.
- Two combinational read ports, one synchronous write port, and a per-register pending-write scoreboard.
- Issue logic claims a destination register; writeback retires the claim. Read ports report data plus a busy flag, with same-cycle write bypass.
- Register 0 reads as zero and is never busy.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
- PEND_W, 2, width of the per-register pending-write counter; max outstanding claims per register = 2**PEND_W-1

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_data1  out  DATA_W  read port 1 data
- rd_busy1  out  1  read port 1 register has an outstanding claim
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data2  out  DATA_W  read port 2 data
- rd_busy2  out  1  read port 2 register has an outstanding claim
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- claim_en  in  1  issue-side claim strobe
- claim_addr  in  ADDR_W  destination register being claimed
- claim_ok  out  1  combinational; claim accepted this cycle
- flush  in  1  synchronous clear of all pending counters
- err_underflow  out  1  sticky; a write retired a register with zero pending
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data

Behaviour:
- Reset (async, rst=1): all registers = 0; all pending counters = 0; err_underflow = 0. Read outputs follow from the zeroed state.
- Writes:
  - On posedge, when wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - Writes to address 0 are discarded.
- Reads (combinational, zero latency):
  - rd_dataN = 0 if rd_addrN==0.
  - Otherwise, if wr_en=1 and wr_addr==rd_addrN, rd_dataN = wr_data (bypass).
  - Otherwise rd_dataN = reg[rd_addrN].
- Busy (combinational):
  - rd_busyN = 1 when pend[rd_addrN] != 0, EXCEPT:
    - it is 0 when rd_addrN==0;
    - it is 0 when the bypassing write reduces pend[rd_addrN] from 1 to 0 this cycle.
- Pending counters, per register r != 0, evaluated each posedge:
  - inc = claim_en & claim_ok & (claim_addr==r)
  - dec = wr_en & (wr_addr==r) & (pend[r]!=0)
  - inc&dec: unchanged; inc only: +1; dec only: -1.
  - pend[0] is constant 0.
- claim_ok:
  - 1 if claim_addr==0 (no-op claim).
  - 1 if pend[claim_addr] < 2**PEND_W-1.
  - 1 if a same-cycle retiring write to claim_addr exists.
  - Else 0. A rejected claim changes no state; issue logic must stall and retry.
- Underflow: wr_en=1, wr_addr!=0, pend[wr_addr]==0 and no same-cycle claim to wr_addr:
  - data is still written;
  - counter stays 0;
  - err_underflow <= 1 until rst.
- Flush:
  - On posedge with flush=1, all counters <= 0; register contents are untouched.
  - A write in the same cycle is performed.
  - Flush overrides claim and dec updates.
- Reset asserted mid-operation: state clears immediately; writes/claims presented during reset are lost.

Optional Feature:
- Macro REGFILE_DEBUG_EN.
- Defined: dbg_data = reg[dbg_addr], combinational, no bypass; dbg_addr==0 gives 0.
- Undefined: dbg_data tied to 0; dbg_addr ignored; no extra read mux synthesised.

Test Plan:
- Reset, then read every address on both ports -> rd_data=0 and rd_busy=0 for all.
- Claim r5; next cycle rd_addr1=5 -> rd_busy1=1. Write r5=0xDEADBEEF with rd_addr1=5 in the same cycle -> rd_data1=0xDEADBEEF, rd_busy1=0 that cycle. Next cycle reg holds it, busy=0.
- PEND_W=2: claim r7 three times -> claim_ok=1 each. Fourth claim -> claim_ok=0. Fourth claim with a same-cycle write to r7 -> claim_ok=1 and pend stays 3.
- Write r0=0x12345678, claim r0 -> rd_data(0)=0, busy=0, claim_ok=1, no underflow.
- Write r9=0xA5 with no claim -> r9 reads 0xA5, err_underflow=1 and held. Claim r3 twice, assert flush -> rd_busy for r3=0, r9 still 0xA5.
- Assert rst asynchronously between edges after writing r4=0x55 -> r4 reads 0 immediately; with REGFILE_DEBUG_EN, dbg_addr=4 reads 0, else dbg_data=0 always.
